// File: rtl/adder_result_collector_if.sv
// Stream bundle between the adder FU, the result collector and the tile's output routing.
// The collector side uses the slave modport; the FU/consumer side uses master.
interface adder_result_collector_if #(
    parameter int WIDTH = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic [3:0][WIDTH-1:0]  in_results;
    logic                   in_carry;
    logic [1:0]             in_config;

    logic                   out_valid;
    logic                   out_ready;
    logic [4*WIDTH-1:0]     out_data;
    logic [1:0]             out_index;
    logic                   out_last;
    logic                   out_carry;

    modport master (
        output in_valid, in_results, in_carry, in_config, out_ready,
        input  in_ready, out_valid, out_data, out_index, out_last, out_carry
    );

    modport slave (
        input  in_valid, in_results, in_carry, in_config, out_ready,
        output in_ready, out_valid, out_data, out_index, out_last, out_carry
    );
endinterface

// File: rtl/adder_result_collector.sv
// Captures adder FU lane results into a small FIFO and serializes each entry as 1, 2 or 4
// words depending on its lane configuration; illegal configurations are dropped and flagged.
module adder_result_collector #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    adder_result_collector_if.slave  bus,
    output logic [$clog2(DEPTH):0]   occupancy_o,
    output logic                     err_cfg_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;
    localparam logic [1:0] CFG_ILLEGAL = 2'd2;

    logic [3:0][WIDTH-1:0] res_q [DEPTH];
    logic [DEPTH-1:0]      carry_q;
    logic [1:0]            cfg_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [OW-1:0] occ_q, occ_d;
    logic [1:0]    wc_q, wc_d;
    logic          err_q, err_d;

    logic                  empty, full, accept, store, xfer, pop;
    logic [3:0][WIDTH-1:0] head_res;
    logic                  head_carry;
    logic [1:0]            head_cfg;
    logic [1:0]            last_wc;

    assign empty      = (occ_q == '0);
    assign full       = (occ_q == OW'(DEPTH));
    assign head_res   = res_q[rd_ptr_q];
    assign head_carry = carry_q[rd_ptr_q];
    assign head_cfg   = cfg_q[rd_ptr_q];

    // in_ready sees only registered state (plus reset), never out_ready.
    assign bus.in_ready = reset_ni && !full;
    assign accept       = bus.in_valid && bus.in_ready;
    assign store        = accept && (bus.in_config != CFG_ILLEGAL);

    always_comb begin
        last_wc = 2'd0;
        case (head_cfg)
            2'd0:    last_wc = 2'd3;
            2'd1:    last_wc = 2'd1;
            default: last_wc = 2'd0;
        endcase
    end

    always_comb begin
        bus.out_valid = !empty;
        bus.out_index = '0;
        bus.out_last  = 1'b0;
        bus.out_carry = 1'b0;
        bus.out_data  = '0;
        if (!empty) begin
            bus.out_index = wc_q;
            bus.out_last  = (wc_q == last_wc);
            bus.out_carry = (wc_q == last_wc) && head_carry;
            case (head_cfg)
                2'd0: bus.out_data[WIDTH-1:0] = head_res[wc_q];
                2'd1: begin
                    if (wc_q[0])
                        bus.out_data[2*WIDTH-1:0] = {head_res[3], head_res[2]};
                    else
                        bus.out_data[2*WIDTH-1:0] = {head_res[1], head_res[0]};
                end
                default: bus.out_data = head_res;
            endcase
        end
    end

    assign xfer = bus.out_valid && bus.out_ready;
    assign pop  = xfer && bus.out_last;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(store);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        occ_d    = occ_q + OW'(store) - OW'(pop);
        err_d    = err_q || (accept && (bus.in_config == CFG_ILLEGAL));
        wc_d     = wc_q;
        if (pop)
            wc_d = 2'd0;
        else if (xfer)
            wc_d = wc_q + 2'd1;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            wc_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            wc_q     <= wc_d;
            err_q    <= err_d;
        end
    end

    // Entry storage needs no reset: validity is tracked entirely by the pointers.
    always_ff @(posedge clk_i) begin
        if (store) begin
            res_q[wr_ptr_q]   <= bus.in_results;
            carry_q[wr_ptr_q] <= bus.in_carry;
            cfg_q[wr_ptr_q]   <= bus.in_config;
        end
    end

    assign occupancy_o = occ_q;
    assign err_cfg_o   = err_q;

endmodule
